fb_read_sequencer: RTL and testbench

- Sequences raster-order reads of an H_COUNT x V_COUNT pixel framebuffer BRAM port B and hands each pixel to the SPI transmit path over a valid/ready handshake.
- Owns the per-frame address generation, BRAM read-latency tracking, read pacing and frame start/done signalling.
- Sits between the framebuffer BRAM (read port) and the SPI peripheral TX serializer.

---
 rtl/fb_read_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_fb_read_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_read_sequencer.sv
// rtl/fb_read_sequencer.sv - raster-order framebuffer reader feeding the SPI TX path over valid/ready.
// Optional continuous streaming when FB_READ_SEQ_CONTINUOUS_EN is defined.
module fb_read_sequencer #(
    parameter int H_COUNT      = 10,
    parameter int V_COUNT      = 8,
    parameter int PIXEL_WIDTH  = 8,
    parameter int BRAM_LATENCY = 2,
    parameter int READ_PERIOD  = 12
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 start_in,
    input  logic                                 abort_in,
    output logic                                 rd_en_out,
    output logic [$clog2(H_COUNT*V_COUNT)-1:0]   addr_out,
    input  logic [PIXEL_WIDTH-1:0]               bram_data_in,
    output logic [PIXEL_WIDTH-1:0]               pixel_out,
    output logic                                 pixel_valid_out,
    input  logic                                 pixel_ready_in,
    output logic                                 pixel_last_out,
    output logic [$clog2(H_COUNT)-1:0]           hcount_out,
    output logic [$clog2(V_COUNT)-1:0]           vcount_out,
    output logic                                 busy_out,
    output logic                                 done_out
);

    localparam int AW = $clog2(H_COUNT*V_COUNT);
    localparam int HW = $clog2(H_COUNT);
    localparam int VW = $clog2(V_COUNT);
    localparam int PW = $clog2(READ_PERIOD+1);
    localparam int LW = $clog2(BRAM_LATENCY+1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_COUNT-1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_COUNT-1);
    localparam logic [PW-1:0] PACE_LOAD = PW'(READ_PERIOD-1);
    localparam logic [LW-1:0] LAT_LOAD  = LW'(BRAM_LATENCY-1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [HW-1:0]          h_q, h_d;
    logic [VW-1:0]          v_q, v_d;
    logic [AW-1:0]          lin_q, lin_d;
    logic [PW-1:0]          pace_q, pace_d;
    logic [LW-1:0]          lat_q, lat_d;
    logic                   rd_en_q, rd_en_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [VW-1:0]          vcnt_q, vcnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [PW-1:0]          pace_dec;
    logic                   handshake;
    logic                   frame_last;

    assign pace_dec   = (pace_q == '0) ? '0 : pace_q - PW'(1);
    assign handshake  = valid_q && pixel_ready_in;
    assign frame_last = (h_q == H_LAST) && (v_q == V_LAST);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        lin_d   = lin_q;
        pace_d  = pace_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        pixel_d = pixel_q;
        valid_d = valid_q;
        last_d  = last_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            pace_d = pace_dec;
        end

        case (state_q)
            S_IDLE: begin
                if (start_in && !abort_in) begin
                    state_d = S_ISSUE;
                    h_d     = '0;
                    v_d     = '0;
                    lin_d   = '0;
                    pace_d  = '0;
                    lat_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                pace_d  = PACE_LOAD;
                lat_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    pixel_d = bram_data_in;
                    hcnt_d  = h_q;
                    vcnt_d  = v_q;
                    valid_d = 1'b1;
                    last_d  = frame_last;
                    state_d = S_PRESENT;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            S_PRESENT: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (frame_last) begin
                        done_d = 1'b1;
`ifdef FB_READ_SEQ_CONTINUOUS_EN
                        h_d     = '0;
                        v_d     = '0;
                        lin_d   = '0;
                        state_d = S_GAP;
`else
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
`endif
                    end else begin
                        lin_d = lin_q + AW'(1);
                        if (h_q == H_LAST) begin
                            h_d = '0;
                            v_d = v_q + VW'(1);
                        end else begin
                            h_d = h_q + HW'(1);
                        end
                        // A long stall may already have expired the pacing window.
                        state_d = (pace_dec == '0) ? S_ISSUE : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (pace_dec == '0) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats any handshake or pending BRAM result in the same cycle.
        if (abort_in && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end

        rd_en_d = (state_d == S_ISSUE);
        if (rd_en_d) begin
            addr_d = lin_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            lin_q   <= '0;
            pace_q  <= '0;
            lat_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            pixel_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            lin_q   <= lin_d;
            pace_q  <= pace_d;
            lat_q   <= lat_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rd_en_out       = rd_en_q;
    assign addr_out        = addr_q;
    assign pixel_out       = pixel_q;
    assign pixel_valid_out = valid_q;
    assign pixel_last_out  = last_q;
    assign hcount_out      = hcnt_q;
    assign vcount_out      = vcnt_q;
    assign busy_out        = busy_q;
    assign done_out        = done_q;

endmodule

// File: tb/tb_fb_read_sequencer.sv
// tb/tb_fb_read_sequencer.sv - scoreboard bench for fb_read_sequencer with a BRAM model and frame reference model.
module tb_fb_read_sequencer;
    localparam int H  = 10;
    localparam int V  = 8;
    localparam int PX = 8;
    localparam int L  = 2;
    localparam int RP = 12;
    localparam int N  = H * V;
    localparam int AW = $clog2(N);
    localparam int HW = $clog2(H);
    localparam int VW = $clog2(V);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic ready = 1'b1;
    logic rd_en;
    logic [AW-1:0] addr;
    logic [PX-1:0] bram;
    logic [PX-1:0] pixel;
    logic valid, last, busy, done;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    fb_read_sequencer #(.H_COUNT(H), .V_COUNT(V), .PIXEL_WIDTH(PX),
                        .BRAM_LATENCY(L), .READ_PERIOD(RP)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort),
        .rd_en_out(rd_en), .addr_out(addr), .bram_data_in(bram),
        .pixel_out(pixel), .pixel_valid_out(valid), .pixel_ready_in(ready),
        .pixel_last_out(last), .hcount_out(hcnt), .vcount_out(vcnt),
        .busy_out(busy), .done_out(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // BRAM model: data valid exactly L cycles after the read strobe, junk otherwise.
    logic [PX-1:0] mem [0:127];
    logic          pv [L];
    logic [AW-1:0] pa [L];
    initial for (int i = 0; i < L; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    always @(posedge clk) begin
        pv[0] <= rd_en;
        pa[0] <= addr;
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign bram = pv[L-1] ? mem[pa[L-1]] : ~mem[pa[L-1]];

    typedef struct packed {
        logic [PX-1:0] px;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic          last;
    } exp_t;

    exp_t exp_pix[$];
    int   exp_addr[$];
    bit   active = 0;
    bit   pend = 0;
    bit   done_pend = 0;
    int   next_rd = -1;
    int   last_rd = 0;
    int   vstart = 0;

    function automatic void push_frame();
        exp_t e;
        for (int a = 0; a < N; a++) begin
            e.px   = mem[a];
            e.h    = HW'(a % H);
            e.v    = VW'(a / H);
            e.last = (a == N - 1);
            exp_pix.push_back(e);
            exp_addr.push_back(a);
        end
    endfunction

    // Monitor / reference model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            active = 0; pend = 0; done_pend = 0; next_rd = -1;
            exp_pix.delete();
            exp_addr.delete();
        end else begin
            bit was_active;
            bit exp_rd;
            bit exp_v;
            exp_t e;
            was_active = active;
            exp_rd = was_active && (next_rd == cyc);
            chk("busy", busy, was_active);
            chk("done", done, done_pend);
            done_pend = 0;
            chk("rd_en", rd_en, exp_rd);
            if (rd_en && exp_rd) begin
                if (exp_addr.size() == 0) chk("addr_queue_empty", 1, 0);
                else chk("addr", addr, exp_addr.pop_front());
                last_rd = cyc;
                pend    = 1;
                vstart  = cyc + L + 1;
                next_rd = -1;
            end
            exp_v = pend && (cyc >= vstart);
            chk("valid", valid, exp_v);
            if (valid) begin
                if (exp_pix.size() == 0) chk("pix_queue_empty", 1, 0);
                else begin
                    e = exp_pix[0];
                    chk("pixel", pixel, e.px);
                    chk("hcount", hcnt, e.h);
                    chk("vcount", vcnt, e.v);
                    chk("last", last, e.last);
                end
            end else begin
                chk("last_without_valid", last, 0);
            end

            if (was_active && abort) begin
                active = 0; pend = 0; next_rd = -1;
                exp_pix.delete();
                exp_addr.delete();
            end else if (was_active && valid && ready && exp_v) begin
                if (exp_pix.size() != 0) e = exp_pix.pop_front();
                pend = 0;
                if (e.last) begin
                    done_pend = 1;
`ifdef FB_READ_SEQ_CONTINUOUS_EN
                    push_frame();
                    next_rd = imax(last_rd + RP, cyc + 2);
`else
                    active  = 0;
                    next_rd = -1;
`endif
                end else begin
                    next_rd = imax(last_rd + RP, cyc + 1);
                end
            end else if (!was_active && start && !abort) begin
                active  = 1;
                push_frame();
                next_rd = cyc + 1;
            end
        end
    end

    // Ready driver: 0 = always ready, 1 = 30-cycle stall on pixel (5,0), 2 = random.
    int ready_mode = 0;
    int stall_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: ready = 1'b1;
            1: begin
                if (valid && hcnt == 4'd5 && vcnt == 3'd0 && stall_cnt < 30) begin
                    ready = 1'b0;
                    stall_cnt++;
                end else begin
                    ready = 1'b1;
                end
            end
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic pulse_start();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit poke);
        bit found = 0;
        int n = 0;
        while (n < budget && !found) begin
            @(posedge clk); #2;
            start = poke && ($urandom_range(0, 49) == 0);
            if (done) found = 1;
            n++;
        end
        start = 1'b0;
        if (!found) chk("done_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_pixel"}, pixel, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_hcount"}, hcnt, 0);
        chk({tag, "_vcount"}, vcnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 128; i++) mem[i] = PX'($urandom);
    endtask

    initial begin
        bit found;
        randomize_mem();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        ready_mode = 0;
        pulse_start();
        wait_done(3000, 0);
        repeat (5) @(posedge clk);

        randomize_mem();
        stall_cnt  = 0;
        ready_mode = 1;
        pulse_start();
        wait_done(4000, 1);
        repeat (5) @(posedge clk);

        ready_mode = 2;
        pulse_start();
        found = 0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(posedge clk); #2;
            if (rd_en && addr == AW'(40)) found = 1;
        end
        if (!found) chk("addr40_timeout", 0, 1);
        @(posedge clk); #2;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        repeat (20) @(posedge clk);
        pulse_start();
        wait_done(5000, 0);
        repeat (5) @(posedge clk);

        @(posedge clk); #2;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
        repeat (10) @(posedge clk);

        ready_mode = 0;
        pulse_start();
        found = 0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(posedge clk); #2;
            if (valid && last) found = 1;
        end
        if (!found) chk("last_timeout", 0, 1);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        repeat (20) @(posedge clk);

        ready_mode = 2;
        pulse_start();
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid");
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);

`ifdef FB_READ_SEQ_CONTINUOUS_EN
        ready_mode = 0;
        pulse_start();
        wait_done(3000, 0);
        wait_done(3000, 1);
        repeat (30) @(posedge clk);
        #2;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        repeat (10) @(posedge clk);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
